// File: rtl/repvgg_acc_pkg.sv
// Shared types and helpers for the RepVGG partial-sum accumulator.
package repvgg_acc_pkg;

    // Control carried alongside each beat from S1 into S2.
    typedef struct packed {
        logic first;
        logic last;
        logic relu;
    } beat_ctl_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bit offset of row r, lane i in the flattened conv3 bus.
    function automatic int row_lo(input int r, input int i, input int dp, input int w);
        return w * (r * dp + i);
    endfunction

    // Bit offset of lane i in a flattened single-row bus.
    function automatic int lane_lo(input int i, input int w);
        return w * i;
    endfunction

    // Signed saturation to out_dw bits: detect overflow above the max and below the min.
    function automatic logic sat_over(input logic signed [63:0] v, input int out_dw);
        return v > ((64'sd1 <<< (out_dw - 1)) - 64'sd1);
    endfunction

    function automatic logic sat_under(input logic signed [63:0] v, input int out_dw);
        return v < -(64'sd1 <<< (out_dw - 1));
    endfunction

endpackage

// File: rtl/psum_lane.sv
// One output lane: S1 branch adder, S2 group accumulator, ReLU and saturation.
module psum_lane
    import repvgg_acc_pkg::*;
#(
    parameter int IN_DW    = 32,
    parameter int ACC_DW   = 40,
    parameter int OUT_DW   = 32,
    parameter int CHNL_NUM = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ld,
    input  logic                               adv,
    input  logic                               c1_en,
    input  logic                               ori_en,
    input  logic                               s1_first,
    input  logic                               s1_last,
    input  logic                               s1_relu,
    input  logic [CHNL_NUM-1:0][IN_DW-1:0]     conv3,
    input  logic [IN_DW-1:0]                   conv1,
    input  logic [IN_DW-1:0]                   ori,
    output logic [OUT_DW-1:0]                  res,
    output logic                               sat_hit
);

    logic signed [ACC_DW-1:0] sum_c, sum_r, acc_r, acc_new, relu_v;
    logic signed [63:0]       acc64;
    logic                     over, under;
    logic [OUT_DW-1:0]        res_c;

    // Sign-extend every enabled branch term and add them for this beat.
    always_comb begin
        sum_c = '0;
        for (int r = 0; r < CHNL_NUM; r++)
            sum_c = sum_c + ACC_DW'($signed(conv3[r]));
        if (c1_en)  sum_c = sum_c + ACC_DW'($signed(conv1));
        if (ori_en) sum_c = sum_c + ACC_DW'($signed(ori));
    end

    // S1: hold the beat sum until S2 consumes it.
    always_ff @(posedge clk) begin
        if (rst)     sum_r <= '0;
        else if (ld) sum_r <= sum_c;
    end

    // A first beat restarts the group; the accumulator itself wraps at ACC_DW.
    assign acc_new = s1_first ? sum_r : acc_r + sum_r;
    assign relu_v  = (s1_relu && acc_new[ACC_DW-1]) ? '0 : acc_new;
    assign acc64   = 64'(relu_v);
    assign over    = sat_over(acc64, OUT_DW);
    assign under   = sat_under(acc64, OUT_DW);
    assign sat_hit = over | under;
    assign res_c   = over  ? {1'b0, {(OUT_DW-1){1'b1}}} :
                     under ? {1'b1, {(OUT_DW-1){1'b0}}} : relu_v[OUT_DW-1:0];

    // S2: accumulate; register the clipped result when the group closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            res   <= '0;
        end else if (adv) begin
            acc_r <= acc_new;
            if (s1_last) res <= res_c;
        end
    end

endmodule

// File: rtl/psum_accumulator_v2.sv
// RepVGG partial-sum accumulator: handshake, framing, flags and DP lane instances.
module psum_accumulator_v2
    import repvgg_acc_pkg::*;
#(
    parameter int IN_DW    = 32,
    parameter int ACC_DW   = 40,
    parameter int OUT_DW   = 32,
    parameter int DP       = 56,
    parameter int CHNL_NUM = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_c1_en,
    input  logic                          cfg_ori_en,
    input  logic                          cfg_relu,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [CHNL_NUM*DP*IN_DW-1:0]  data_i_conv3,
    input  logic [DP*IN_DW-1:0]           data_i_conv1,
    input  logic [DP*IN_DW-1:0]           data_i_ori,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DP*OUT_DW-1:0]          data_o,
    output logic                          sat_flag,
    output logic                          err_flag
);

    localparam int STAGES = 2;

    // vld_pipe[1]: S1 holds a beat; vld_pipe[2]: data_o holds a result.
    logic [STAGES:1]            vld_pipe;
    beat_ctl_t                  s1_ctl;
    logic                       in_group;
    logic                       en, acc_beat, frame_err;
    logic [DP-1:0]              lane_sat;
    logic [DP-1:0][OUT_DW-1:0]  res;

    // The whole pipe moves together; only a held result blocks it.
    assign en        = !vld_pipe[2] | out_ready;
    assign in_ready  = en;
    assign acc_beat  = in_valid & en;
    assign out_valid = vld_pipe[2];
    assign data_o    = res;
    // Either a first inside an open group or a continuation with no open group.
    assign frame_err = acc_beat & (in_first == in_group);

    // Valid pipeline, beat framing and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_ctl   <= '0;
            in_group <= 1'b0;
            sat_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (en) begin
                vld_pipe[1] <= in_valid;
                vld_pipe[2] <= vld_pipe[1] & s1_ctl.last;
            end
            if (acc_beat) begin
                // An orphan continuation beat opens a fresh group.
                s1_ctl   <= '{first: in_first | !in_group, last: in_last, relu: cfg_relu};
                in_group <= !in_last;
            end
            if (frame_err) err_flag <= 1'b1;
            if (en && vld_pipe[1] && s1_ctl.last && |lane_sat) sat_flag <= 1'b1;
        end
    end

    for (genvar i = 0; i < DP; i++) begin : g_lane
        logic [CHNL_NUM-1:0][IN_DW-1:0] c3;
        for (genvar r = 0; r < CHNL_NUM; r++) begin : g_row
            assign c3[r] = data_i_conv3[row_lo(r, i, DP, IN_DW) +: IN_DW];
        end
        psum_lane #(
            .IN_DW   (IN_DW),
            .ACC_DW  (ACC_DW),
            .OUT_DW  (OUT_DW),
            .CHNL_NUM(CHNL_NUM)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .ld      (acc_beat),
            .adv     (en & vld_pipe[1]),
            .c1_en   (cfg_c1_en),
            .ori_en  (cfg_ori_en),
            .s1_first(s1_ctl.first),
            .s1_last (s1_ctl.last),
            .s1_relu (s1_ctl.relu),
            .conv3   (c3),
            .conv1   (data_i_conv1[lane_lo(i, IN_DW) +: IN_DW]),
            .ori     (data_i_ori[lane_lo(i, IN_DW) +: IN_DW]),
            .res     (res[i]),
            .sat_hit (lane_sat[i])
        );
    end

endmodule

// File: tb/tb_psum_accumulator_v2.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops on each output transfer.
module tb_psum_accumulator_v2;

    localparam int IN_DW = 32, ACC_DW = 40, OUT_DW = 32, DP = 4, CH = 3;
    localparam int VW = DP * OUT_DW;

    logic clk = 0, rst = 1;
    logic cfg_c1_en = 0, cfg_ori_en = 0, cfg_relu = 0;
    logic in_valid = 0, in_first = 0, in_last = 0, out_ready = 1;
    logic in_ready, out_valid, sat_flag, err_flag;
    logic [CH*DP*IN_DW-1:0] data_i_conv3 = '0;
    logic [DP*IN_DW-1:0]    data_i_conv1 = '0, data_i_ori = '0;
    logic [VW-1:0]          data_o;

    int total = 0, bad = 0;
    logic [VW-1:0] expq[$];

    psum_accumulator_v2 #(.IN_DW(IN_DW), .ACC_DW(ACC_DW), .OUT_DW(OUT_DW), .DP(DP), .CHNL_NUM(CH)) dut (
        .clk(clk), .rst(rst), .cfg_c1_en(cfg_c1_en), .cfg_ori_en(cfg_ori_en), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .data_i_conv3(data_i_conv3), .data_i_conv1(data_i_conv1), .data_i_ori(data_i_ori),
        .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o),
        .sat_flag(sat_flag), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Lane i expects base + i*step.
    function automatic logic [VW-1:0] lin(input logic [31:0] base, input int step);
        logic [VW-1:0] v;
        for (int i = 0; i < DP; i++) v[32*i +: 32] = base + 32'(i * step);
        return v;
    endfunction

    task automatic check(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance. Row 0 of lane i gets +i*delta.
    task automatic send(input bit f, input bit l, input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] c1, input logic [31:0] o,
                        input bit c1e, input bit oe, input bit rl, input int delta);
        bit ok;
        int n;
        in_valid = 1; in_first = f; in_last = l;
        cfg_c1_en = c1e; cfg_ori_en = oe; cfg_relu = rl;
        for (int i = 0; i < DP; i++) begin
            data_i_conv3[32*(0*DP+i) +: 32] = r0 + 32'(i * delta);
            data_i_conv3[32*(1*DP+i) +: 32] = r1;
            data_i_conv3[32*(2*DP+i) +: 32] = r2;
            data_i_conv1[32*i +: 32] = c1;
            data_i_ori[32*i +: 32]   = o;
        end
        ok = 0; n = 0;
        while (!ok && n < 60) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); n++;
        end
        #1 in_valid = 0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout got=not_accepted exp=accepted");
        end
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Monitor: every output transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got=%h exp=none", data_o);
            end else begin
                logic [VW-1:0] e;
                e = expq.pop_front();
                if (data_o !== e) begin
                    bad++;
                    $display("FAIL result got=%h exp=%h", data_o, e);
                end
            end
        end
    end

    initial begin
        logic [VW-1:0] ea;
        int n;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        check("rst_out_valid", VW'(out_valid), '0);
        check("rst_data_o", data_o, '0);
        check("rst_sat", VW'(sat_flag), '0);
        check("rst_err", VW'(err_flag), '0);
        check("rst_in_ready", VW'(in_ready), VW'(1));

        // Single beat: 1+2+3+4+5 = 15 (+lane), two-cycle latency
        expq.push_back(lin(15, 1));
        send(1, 1, 1, 2, 3, 4, 5, 1, 1, 0, 1);
        @(negedge clk); check("lat_cyc1", VW'(out_valid), '0);
        @(negedge clk); check("lat_cyc2", VW'(out_valid), VW'(1));
        @(posedge clk); #1;

        // Four beats of 300 each, conv1/ori disabled: 1200 (+4 per lane step)
        expq.push_back(lin(1200, 4));
        send(1, 0, 100, 100, 100, 7, 9, 0, 0, 0, 1);
        send(0, 0, 100, 100, 100, 7, 9, 0, 0, 0, 1);
        send(0, 0, 100, 100, 100, 7, 9, 0, 0, 0, 1);
        send(0, 1, 100, 100, 100, 7, 9, 0, 0, 0, 1);
        drain();

        // ReLU: -7 -> 0; without ReLU -> -7; per-lane -7,-2,3,8 -> 0,0,3,8
        expq.push_back(lin(0, 0));
        send(1, 1, 32'hFFFFFFF6, 1, 2, 0, 0, 0, 0, 1, 0);
        expq.push_back(lin(32'hFFFFFFF9, 0));
        send(1, 1, 32'hFFFFFFF6, 1, 2, 0, 0, 0, 0, 0, 0);
        ea = {32'd8, 32'd3, 32'd0, 32'd0};
        expq.push_back(ea);
        send(1, 1, 32'hFFFFFFF6, 1, 2, 0, 0, 0, 0, 1, 5);
        drain();

        // Exact boundaries pass through unclipped
        expq.push_back(lin(32'h7FFFFFFF, 0));
        send(1, 1, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        expq.push_back(lin(32'h80000000, 0));
        send(1, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        check("sat_boundary", VW'(sat_flag), '0);

        // 2^31+5 clips high; -2^31-1 clips low; cross-beat overflow clips high
        expq.push_back(lin(32'h7FFFFFFF, 0));
        send(1, 1, 32'h7FFFFFFF, 5, 1, 0, 0, 0, 0, 0, 0);
        drain();
        check("sat_set", VW'(sat_flag), VW'(1));
        expq.push_back(lin(32'h80000000, 0));
        send(1, 1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        expq.push_back(lin(32'h7FFFFFFF, 0));
        send(1, 0, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        send(0, 1, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        // Backpressure: hold out_ready low for 5 cycles with a result waiting
        out_ready = 0;
        ea = lin(111, 1);
        expq.push_back(ea);
        expq.push_back(lin(222, 1));
        expq.push_back(lin(3, 1));
        fork
            begin
                send(1, 1, 100, 10, 1, 0, 0, 0, 0, 0, 1);
                send(1, 1, 200, 20, 2, 0, 0, 0, 0, 0, 1);
                send(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
            end
            begin
                n = 0;
                while (!out_valid && n < 20) begin @(negedge clk); n++; end
                check("stall_ov", VW'(out_valid), VW'(1));
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", VW'(in_ready), '0);
                    check("stall_data", data_o, ea);
                end
                @(posedge clk); #1 out_ready = 1;
            end
        join
        drain();

        // Second first without last: err, result is second group only (10+20)
        check("err_clear", VW'(err_flag), '0);
        expq.push_back(lin(30, 0));
        send(1, 0, 1000, 0, 0, 0, 0, 0, 0, 0, 0);
        send(1, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        send(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        check("err_set", VW'(err_flag), VW'(1));

        // Reset mid-group: no output, flags cleared, group state cleared
        send(1, 0, 77, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        drain();
        check("rst_err_clr", VW'(err_flag), '0);
        check("rst_sat_clr", VW'(sat_flag), '0);
        expq.push_back(lin(11, 0));
        send(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        send(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        check("clean_group_no_err", VW'(err_flag), '0);

        // Orphan last beat: treated as first, err raised
        expq.push_back(lin(9, 0));
        send(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        check("orphan_err", VW'(err_flag), VW'(1));

        check("queue_empty", VW'(expq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
